// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and constants for the instruction-memory arbiter.
//   arb_state_e    - arbiter FSM states
//   grant_e        - requester identity, used by the round-robin pointer
//   BEATS_PER_WORD - byte beats per 32-bit word on the byte-wide memory port
package imem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_LAST,
    ST_RESP,
    ST_WR,
    ST_ACK
  } arb_state_e;

  typedef enum logic {
    GNT_FETCH,
    GNT_LD
  } grant_e;

  localparam int BEATS_PER_WORD = 4;

endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: CPU fetch port, loader write port and byte-wide memory port
// of the instruction-memory arbiter.
//   slave  - the arbiter side (accepts requests, drives the memory port)
//   master - the requester / memory side
// Optional feature macro: IMEM_ARB_MISALIGN_CHK_EN adds fetch_rsp_err.
interface imem_arbiter_if #(
  parameter int ADDR_W = 5
);
  logic              fetch_valid;
  logic              fetch_ready;
  logic [31:0]       fetch_addr;
  logic              fetch_rsp_valid;
  logic              fetch_rsp_ready;
  logic [31:0]       fetch_rsp_data;
`ifdef IMEM_ARB_MISALIGN_CHK_EN
  logic              fetch_rsp_err;
`endif
  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_data;
  logic              ld_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  fetch_valid, fetch_addr, fetch_rsp_ready,
    input  ld_valid, ld_addr, ld_data, mem_rdata,
    output fetch_ready, fetch_rsp_valid, fetch_rsp_data,
    output ld_ready, ld_ack, mem_en, mem_we, mem_addr, mem_wdata
`ifdef IMEM_ARB_MISALIGN_CHK_EN
    , output fetch_rsp_err
`endif
  );

  modport master (
    output fetch_valid, fetch_addr, fetch_rsp_ready,
    output ld_valid, ld_addr, ld_data, mem_rdata,
    input  fetch_ready, fetch_rsp_valid, fetch_rsp_data,
    input  ld_ready, ld_ack, mem_en, mem_we, mem_addr, mem_wdata
`ifdef IMEM_ARB_MISALIGN_CHK_EN
    , input fetch_rsp_err
`endif
  );

endinterface

// File: rtl/imem_arbiter_rr.sv
// rr_arbiter2: two-requester round-robin arbiter.
//   clk, rst          - clock, synchronous active-high reset
//   en                - grants are only issued while en is high
//   req_fetch, req_ld - requests
//   gnt_fetch, gnt_ld - one-hot (or zero) grants, combinational from requests
// Every grant is an accept, so the tie-break pointer moves to the other
// requester whenever a grant is issued. After reset fetch wins ties.
module rr_arbiter2
  import imem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_fetch,
  input  logic req_ld,
  output logic gnt_fetch,
  output logic gnt_ld
);

  grant_e prio_q, prio_d;  // requester preferred on a tie

  always_comb begin
    gnt_fetch = 1'b0;
    gnt_ld    = 1'b0;
    prio_d    = prio_q;
    if (en) begin
      if (req_fetch && (!req_ld || prio_q == GNT_FETCH)) begin
        gnt_fetch = 1'b1;
        prio_d    = GNT_LD;
      end else if (req_ld) begin
        gnt_ld = 1'b1;
        prio_d = GNT_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= GNT_FETCH;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a byte-wide instruction memory between a CPU fetch
// port (word reads) and a loader port (word writes).
//   clk, rst - clock, synchronous active-high reset
//   bus      - imem_arbiter_if.slave: fetch request/response, loader
//              request/ack, byte-wide memory port
// Each word is moved as four byte beats, little-endian (beat k = bits 8k+7:8k).
// Optional feature macro: IMEM_ARB_MISALIGN_CHK_EN - misaligned requests skip
// the memory, fetches answer 0 with fetch_rsp_err, loads just acknowledge.
//
// state      | meaning
// ST_IDLE    | ready for a new request, arbitration active
// ST_RD      | issuing read beats 0..3, capturing the previous beat's byte
// ST_RD_LAST | capturing byte 3
// ST_RESP    | holding the fetched word until the CPU takes it
// ST_WR      | issuing write beats 0..3
// ST_ACK     | one-cycle ld_ack pulse
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input logic           clk,
  input logic           rst,
  imem_arbiter_if.slave bus
);

  localparam int         WORD_W    = ADDR_W - 2;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_WORD - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic       arb_en, gnt_fetch, gnt_ld;
  logic       fetch_mis, ld_mis;
  logic [1:0] prev_beat;
  logic       unused_bits;

  assign arb_en = (state_q == ST_IDLE) && !rst;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .req_fetch (bus.fetch_valid),
    .req_ld    (bus.ld_valid),
    .gnt_fetch (gnt_fetch),
    .gnt_ld    (gnt_ld)
  );

  assign bus.fetch_ready = gnt_fetch;
  assign bus.ld_ready    = gnt_ld;

`ifdef IMEM_ARB_MISALIGN_CHK_EN
  assign fetch_mis         = |bus.fetch_addr[1:0];
  assign ld_mis            = |bus.ld_addr[1:0];
  assign bus.fetch_rsp_err = err_q && (state_q == ST_RESP);
`else
  assign fetch_mis = 1'b0;
  assign ld_mis    = 1'b0;
`endif

  // Address bits outside the memory and the byte offset carry no meaning here.
  assign unused_bits = ^{bus.fetch_addr[31:ADDR_W], bus.fetch_addr[1:0],
                         bus.ld_addr[31:ADDR_W], bus.ld_addr[1:0], err_q};

  // Read data lags the request by one cycle, so a beat captures its predecessor.
  assign prev_beat = beat_q - 2'd1;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    bus.fetch_rsp_valid = 1'b0;
    bus.fetch_rsp_data  = '0;
    bus.ld_ack          = 1'b0;
    bus.mem_en          = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_wdata       = '0;

    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (gnt_fetch) begin
          word_d  = bus.fetch_addr[ADDR_W-1:2];
          rdata_d = '0;
          err_d   = fetch_mis;
          state_d = fetch_mis ? ST_RESP : ST_RD;
        end else if (gnt_ld) begin
          word_d  = bus.ld_addr[ADDR_W-1:2];
          wdata_d = bus.ld_data;
          err_d   = 1'b0;
          state_d = ld_mis ? ST_ACK : ST_WR;
        end
      end
      ST_RD: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = {word_q, beat_q};
        if (beat_q != 2'd0) rdata_d[{prev_beat, 3'b000} +: 8] = bus.mem_rdata;
        beat_d = beat_q + 2'd1;
        if (beat_q == LAST_BEAT) state_d = ST_RD_LAST;
      end
      ST_RD_LAST: begin
        rdata_d[31:24] = bus.mem_rdata;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        bus.fetch_rsp_valid = 1'b1;
        bus.fetch_rsp_data  = rdata_q;
        if (bus.fetch_rsp_ready) state_d = ST_IDLE;
      end
      ST_WR: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {word_q, beat_q};
        bus.mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
        beat_d = beat_q + 2'd1;
        if (beat_q == LAST_BEAT) state_d = ST_ACK;
      end
      ST_ACK: begin
        bus.ld_ack = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, byte-address width of the shared instruction memory (2**ADDR_W bytes).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 fetch_valid  input  1  CPU fetch request; fetch_ready  output  1  request accepted when both high.
REQ-005 fetch_addr  input  32  fetch byte address; only bits [ADDR_W-1:2] used.
REQ-006 fetch_rsp_valid  output  1  fetched word available; fetch_rsp_ready  input  1  CPU consumes word.
REQ-007 fetch_rsp_data  output  32  fetched instruction, little-endian byte assembly.
REQ-008 ld_valid  input  1  loader word-write request; ld_ready  output  1  accepted when both high.
REQ-009 ld_addr  input  32  loader byte address, bits [ADDR_W-1:2] used; ld_data  input  32  word to write.
REQ-010 ld_ack  output  1  one-cycle pulse on write completion.
REQ-011 mem_en  output  1; mem_we  output  1; mem_addr  output  ADDR_W; mem_wdata  output  8  byte-wide memory port.
REQ-012 mem_rdata  input  8  read byte, valid exactly one cycle after the mem_en/!mem_we cycle.

Function
REQ-013 FSM states IDLE, RD, RD_LAST, RESP, WR, ACK; 2-bit beat counter.
REQ-014 fetch_ready and ld_ready SHALL be high only in IDLE, and never both in a cycle where both valids are high.
REQ-015 In IDLE with one valid high, that requester is granted; both high -> round-robin, requester not granted last wins; after reset fetch wins first.
REQ-016 Accept cycle A latches word address {addr[ADDR_W-1:2]} and ld_data; next state RD or WR, beat=0.
REQ-017 RD: cycles A+1..A+4 drive mem_en=1, mem_we=0, mem_addr={word,beat}, beat 0..3; after beat 3 -> RD_LAST.
REQ-018 Byte beat k captured from mem_rdata in cycle A+2+k into bits [8k+7:8k]; RD_LAST (A+5) captures byte 3 -> RESP.
REQ-019 RESP: fetch_rsp_valid=1 from cycle A+6, data stable, held until fetch_rsp_ready; handshake -> IDLE.
REQ-020 WR: cycles A+1..A+4 drive mem_en=1, mem_we=1, mem_addr={word,beat}, mem_wdata=ld_data byte beat; then ACK.
REQ-021 ACK (A+5): ld_ack=1 for exactly one cycle -> IDLE.
REQ-022 Outside RD/WR: mem_en=0, mem_we=0; mem_addr, mem_wdata hold 0.
REQ-023 Address bits above ADDR_W-1 ignored (wrap modulo memory size); bits [1:0] ignored unless REQ-027.
REQ-024 Requests arriving during non-IDLE states wait; requesters hold valid and payload until accepted.

Reset
REQ-025 rst high at any edge -> state IDLE, beat 0, round-robin pointer to fetch, all outputs 0 next cycle (fetch_ready/ld_ready 0 during rst).
REQ-026 Reset mid-operation abandons the transaction: no fetch_rsp_valid, no ld_ack; bytes already written stay in memory.

Configuration
REQ-027 IMEM_ARB_MISALIGN_CHK_EN defined: adds output fetch_rsp_err (1); fetch with addr[1:0]!=0 skips RD, goes to RESP in A+1 with data 0, err=1; ld with addr[1:0]!=0 skips WR, goes to ACK in A+1, no memory write.
REQ-028 Macro undefined: no fetch_rsp_err port, addr[1:0] ignored.

Structure
REQ-029 Package imem_arb_pkg holds state enum, grant enum {GNT_FETCH, GNT_LD}, constant BEATS_PER_WORD=4.
REQ-030 Sub-module rr_arbiter2 (2-requester round-robin, pointer register, enable input) computes grants.

Verification
REQ-031 Load 0x00500093 at addr 0x4, fetch 0x4 -> ld_ack at A+5, bytes 93,00,50,00 at mem addr 4..7; fetch_rsp_data=0x00500093 at A+6.
REQ-032 fetch_valid and ld_valid both high from reset -> fetch granted first, loader next IDLE; repeat -> alternates.
REQ-033 fetch_rsp_ready low 3 cycles -> fetch_rsp_valid/data held stable, fetch_ready stays 0.
REQ-034 rst at WR beat 2 -> no ld_ack, outputs 0 next cycle, bytes 0..1 written, 2..3 unchanged.
REQ-035 With IMEM_ARB_MISALIGN_CHK_EN, fetch 0x6 -> fetch_rsp_err=1, data 0, no mem_en cycles.
REQ-036 fetch_addr 0x24 (ADDR_W=5) -> memory reads bytes 4..7.
